// File: rtl/bidir_pkg.sv
// Shared types and defaults for the bidir_sel_driver slice.
package bidir_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN   = 2'd1,
    DRIVE  = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  typedef enum logic {
    MODE_IN  = 1'b0,
    MODE_OUT = 1'b1
  } mode_t;

  localparam int unsigned DEF_WIDTH       = 1;
  localparam int unsigned DEF_TURN_CYC    = 2;
  localparam int unsigned DEF_HOLD_CYC    = 1;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bidir_sel_driver_sync.sv
// Multi-flop synchronizer sampling the shared select line.
module sync_chain #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [SYNC_STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/bidir_sel_driver.sv
// Sequenced tristate driver for the mux select line with hi-Z turnaround.
// Optional contention checker: define BIDIR_CONTENTION_CHK_EN.
module bidir_sel_driver
  import bidir_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned TURN_CYC    = DEF_TURN_CYC,
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  inout  wire  [WIDTH-1:0] pad,
  output logic             oe,
  output logic             busy,
  output logic             wr_done,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             contention
);

  localparam int unsigned MAXC = max3(TURN_CYC, HOLD_CYC, SYNC_STAGES + 1);
  localparam int unsigned CW   = $clog2(MAXC) + 1;

  state_t           state, nstate;
  mode_t            mode, nmode;
  logic [CW-1:0]    cnt, ncnt;
  logic [WIDTH-1:0] drv, ndrv;
  logic [WIDTH-1:0] nrd_data;
  logic             nrd_valid;
  logic             is_wr, nis_wr;
  logic [WIDTH-1:0] sync_q;

  sync_chain #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (pad),
    .q   (sync_q)
  );

  assign pad = oe ? drv : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode     <= MODE_IN;
      cnt      <= '0;
      drv      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      is_wr    <= 1'b0;
    end else begin
      state    <= nstate;
      mode     <= nmode;
      cnt      <= ncnt;
      drv      <= ndrv;
      rd_data  <= nrd_data;
      rd_valid <= nrd_valid;
      is_wr    <= nis_wr;
    end
  end

  always_comb begin
    nstate    = state;
    nmode     = mode;
    ncnt      = cnt;
    ndrv      = drv;
    nrd_data  = rd_data;
    nrd_valid = 1'b0;
    nis_wr    = is_wr;
    busy      = (state != IDLE);
    oe        = (state == DRIVE) || ((state == IDLE) && (mode == MODE_OUT));
    wr_done   = (state == DRIVE) && (cnt == CW'(1));
    unique case (state)
      IDLE: begin
        // Write wins over a simultaneous read; the drive register loads at
        // acceptance so an OUT-mode write changes pad with no hi-Z gap.
        if (wr_req) begin
          ndrv   = wr_data;
          nis_wr = 1'b1;
          if (mode == MODE_OUT) begin
            nstate = DRIVE;
            ncnt   = CW'(HOLD_CYC);
          end else begin
            nstate = TURN;
            ncnt   = CW'(TURN_CYC);
          end
        end else if (rd_req) begin
          nis_wr = 1'b0;
          if (mode == MODE_OUT) begin
            nstate = TURN;
            ncnt   = CW'(TURN_CYC);
          end else begin
            nstate = SAMPLE;
            ncnt   = CW'(SYNC_STAGES + 1);
          end
        end
      end
      TURN: begin
        if (cnt <= CW'(1)) begin
          nstate = is_wr ? DRIVE : SAMPLE;
          ncnt   = is_wr ? CW'(HOLD_CYC) : CW'(SYNC_STAGES + 1);
        end else begin
          ncnt = cnt - CW'(1);
        end
      end
      DRIVE: begin
        if (cnt <= CW'(1)) begin
          nstate = IDLE;
          nmode  = MODE_OUT;
        end else begin
          ncnt = cnt - CW'(1);
        end
      end
      SAMPLE: begin
        if (cnt <= CW'(1)) begin
          nstate    = IDLE;
          nmode     = MODE_IN;
          nrd_data  = sync_q;
          nrd_valid = 1'b1;
        end else begin
          ncnt = cnt - CW'(1);
        end
      end
    endcase
  end

`ifdef BIDIR_CONTENTION_CHK_EN
  logic [CW-1:0] age;
  logic          armed, mism, mism_q, contention_q;

  // Arm only once the synchronizer has had time to see the current drive value.
  assign armed = oe && (age >= CW'(SYNC_STAGES));
  assign mism  = armed && (sync_q != drv);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age          <= '0;
      mism_q       <= 1'b0;
      contention_q <= 1'b0;
    end else begin
      if (!oe || (ndrv != drv)) age <= '0;
      else if (!armed)          age <= age + CW'(1);
      mism_q <= mism;
      if (mism && mism_q) contention_q <= 1'b1;
    end
  end

  assign contention = contention_q;
`else
  assign contention = 1'b0;
`endif

endmodule

// File: tb/tb_bidir_sel_driver.sv
// Scoreboard bench for bidir_sel_driver: expected completions queued at issue, popped by a monitor.
module tb_bidir_sel_driver;

  localparam int unsigned W  = 1;
  localparam int unsigned TC = 2;
  localparam int unsigned HC = 1;
  localparam int unsigned SS = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_req = 1'b0;
  logic         rd_req = 1'b0;
  logic [W-1:0] wr_data = '0;
  wire  [W-1:0] pad;
  logic         oe, busy, wr_done, rd_valid, contention;
  logic [W-1:0] rd_data;

  logic         agent_on = 1'b0;
  logic         force_on = 1'b0;
  logic [W-1:0] ext_val  = '0;

  // External agent only drives while the block is released, unless forced.
  assign pad = ((agent_on && !oe) || force_on) ? ext_val : 'z;

  bidir_sel_driver #(.WIDTH(W), .TURN_CYC(TC), .HOLD_CYC(HC), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .rd_req     (rd_req),
    .pad        (pad),
    .oe         (oe),
    .busy       (busy),
    .wr_done    (wr_done),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .contention (contention)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit           is_rd;
    logic [W-1:0] data;
    int unsigned  at;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  bit          mode_out = 1'b0;
  int unsigned free_at  = 0;

  // Downstream 2:1 mux with d0=0, d1=1.
  logic mux_out;
  assign mux_out = pad[0] ? 1'b1 : 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
  endfunction

  // Reference model: latency from mode and acceptance from the busy window.
  task automatic issue(input bit do_wr, input bit do_rd, input logic [W-1:0] d);
    int unsigned c;
    int unsigned lat;
    exp_t e;
    c = cyc;
    wr_req  = do_wr;
    rd_req  = do_rd;
    wr_data = d;
    if ((do_wr || do_rd) && (c >= free_at)) begin
      if (do_wr) begin
        lat      = mode_out ? HC : TC + HC;
        e        = '{is_rd: 1'b0, data: d, at: c + lat};
        free_at  = c + lat + 1;
        mode_out = 1'b1;
      end else begin
        lat      = (mode_out ? TC : 0) + SS + 2;
        e        = '{is_rd: 1'b1, data: ext_val, at: c + lat};
        free_at  = c + lat;
        mode_out = 1'b0;
      end
      sb.push_back(e);
    end
    @(negedge clk);
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic wait_idle();
    while (cyc < free_at) @(negedge clk);
    @(negedge clk);
  endtask

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (wr_done && rd_valid) check("done_valid_overlap", 32'd1, 32'd0);
      if (wr_done || rd_valid) begin
        if (sb.size() == 0) begin
          check("spurious_pulse", {30'd0, rd_valid, wr_done}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("pulse_kind", {31'd0, rd_valid}, {31'd0, e.is_rd});
          check("pulse_cycle", cyc, e.at);
          if (e.is_rd) check("rd_data", 32'(rd_data), 32'(e.data));
          else         check("wr_pad", 32'(pad), 32'(e.data));
        end
      end
    end
  end

  initial begin
    int unsigned c0;
    int unsigned op;
    int unsigned bound;

    // Reset with the agent released
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_oe", {31'd0, oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_contention", {31'd0, contention}, 32'd0);
    rst = 1'b0;
    agent_on = 1'b1;
    ext_val  = '0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_quiet", {30'd0, rd_valid, wr_done}, 32'd0);
    end
    free_at = cyc;

    // Write 1 from IN
    c0 = cyc;
    issue(1'b1, 1'b0, W'(1));
    check("wr_in_c1_oe", {31'd0, oe}, 32'd0);
    check("wr_in_c1_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("wr_in_c2_oe", {31'd0, oe}, 32'd0);
    check("wr_in_c2_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("wr_in_c3_oe", {31'd0, oe}, 32'd1);
    check("wr_in_c3_wr_done", {31'd0, wr_done}, 32'd1);
    check("wr_in_c3_mux", {31'd0, mux_out}, 32'd1);
    @(negedge clk);
    check("wr_in_c4_busy", {31'd0, busy}, 32'd0);
    check("wr_in_c4_cycle", cyc - c0, 32'd4);

    // Back-to-back write 0 while OUT: no hi-Z gap
    issue(1'b1, 1'b0, W'(0));
    check("wr_out_c1_oe", {31'd0, oe}, 32'd1);
    check("wr_out_c1_mux", {31'd0, mux_out}, 32'd0);
    wait_idle();

    // Read after drive: agent supplies 1
    ext_val = W'(1);
    issue(1'b0, 1'b1, '0);
    check("rd_out_c1_oe", {31'd0, oe}, 32'd0);
    repeat (5) @(negedge clk);
    check("rd_out_c6_busy", {31'd0, busy}, 32'd0);
    check("rd_out_c6_valid", {31'd0, rd_valid}, 32'd1);
    wait_idle();

    // Read from IN with pad=0
    ext_val = W'(0);
    issue(1'b0, 1'b1, '0);
    wait_idle();
    check("rd_data_hold", 32'(rd_data), 32'd0);

    // Conflicts: simultaneous requests, then read while busy
    issue(1'b1, 1'b1, W'(1));
    issue(1'b0, 1'b1, '0);
    wait_idle();
    issue(1'b0, 1'b1, '0);
    wait_idle();

    // Reset during TURN of a write from IN
    issue(1'b1, 1'b0, W'(1));
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_oe", {31'd0, oe}, 32'd0);
    sb.delete();
    mode_out = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    free_at = cyc;
    repeat (4) @(negedge clk);
    issue(1'b1, 1'b0, W'(1));
    wait_idle();

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      if (cyc >= free_at) ext_val = W'($urandom);
      op = $urandom_range(0, 3);
      case (op)
        0:       issue(1'b1, 1'b0, W'($urandom));
        1, 3:    issue(1'b0, 1'b1, '0);
        default: issue(1'b1, 1'b1, W'($urandom));
      endcase
    end

    bound = 0;
    while (sb.size() != 0 && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    check("drain_outstanding", sb.size(), 32'd0);

`ifdef BIDIR_CONTENTION_CHK_EN
    wait_idle();
    issue(1'b1, 1'b0, W'(0));
    wait_idle();
    repeat (SS + 2) @(negedge clk);
    check("cont_clear_before", {31'd0, contention}, 32'd0);
    ext_val  = W'(1);
    force_on = 1'b1;
    repeat (SS + 2) @(negedge clk);
    check("cont_set", {31'd0, contention}, 32'd1);
    force_on = 1'b0;
    repeat (4) @(negedge clk);
    check("cont_sticky", {31'd0, contention}, 32'd1);
    rst = 1'b1;
    #1;
    check("cont_rst", {31'd0, contention}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
`else
    check("cont_tied_low", {31'd0, contention}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
